// File: rtl/alu_bcd_seq.sv
// alu_bcd_seq: multi-cycle signed add/sub/mul/div with sign-magnitude
// result and an iterative double-dabble BCD converter for the displays.
module alu_bcd_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 5
) (
  input  logic                clk,
  input  logic                ar,
  input  logic                start,
  input  logic [1:0]          select,
  input  logic [WIDTH-1:0]    a,
  input  logic [WIDTH-1:0]    b,
  output logic                busy,
  output logic                done,
  output logic [WIDTH-1:0]    a_mag,
  output logic [WIDTH-1:0]    b_mag,
  output logic                a_neg,
  output logic                b_neg,
  output logic [2*WIDTH-1:0]  result_mag,
  output logic                result_neg,
  output logic                div_zero,
  output logic [4*DIGITS-1:0] bcd
);
  localparam int RW = 2*WIDTH;
  localparam int BW = 4*DIGITS;
  localparam int CW = $clog2(RW);
  localparam logic [CW-1:0] EXEC_END = CW'(WIDTH-1);
  localparam logic [CW-1:0] CONV_END = CW'(RW-1);

  typedef enum logic [2:0] {
    IDLE, LOAD, EXEC, CONV, DONE
  } state_t;

  state_t state, state_nx;

  logic [WIDTH-1:0] a_l, b_l;
  logic [1:0]       op_l;
  logic [CW-1:0]    cnt;
  logic [RW-1:0]    acc, mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] rem, quo;
  logic [RW-1:0]    res_w, bin_sr;
  logic [BW-1:0]    bcd_sr;
  logic             wneg, wdz;

  logic [WIDTH-1:0] a_abs, b_abs;
  logic [WIDTH:0]   sa, sb, sum, sum_abs;
  logic [RW-1:0]    acc_nx;
  logic [WIDTH:0]   sh, diff;
  logic             ge;
  logic [WIDTH-1:0] rem_nx, quo_nx;
  logic [RW-1:0]    res_nx;
  logic             neg_nx, dz_nx;
  logic [BW-1:0]    adj, bcd_nx;
  logic             exec_last, conv_last;

  assign a_abs = a_l[WIDTH-1] ? '0 - a_l : a_l;
  assign b_abs = b_l[WIDTH-1] ? '0 - b_l : b_l;

  assign sa      = {a_l[WIDTH-1], a_l};
  assign sb      = {b_l[WIDTH-1], b_l};
  assign sum     = op_l[0] ? sa - sb : sa + sb;
  assign sum_abs = sum[WIDTH] ? '0 - sum : sum;

  assign acc_nx = acc + (mplier[0] ? mcand : '0);

  // restoring step: the trial difference's msb doubles as the borrow
  assign sh     = {rem, quo[WIDTH-1]};
  assign diff   = sh - {1'b0, b_mag};
  assign ge     = ~diff[WIDTH];
  assign rem_nx = ge ? diff[WIDTH-1:0] : sh[WIDTH-1:0];
  assign quo_nx = {quo[WIDTH-2:0], ge};

  assign exec_last = (state == EXEC) &&
                     (!op_l[1] || cnt == EXEC_END);
  assign conv_last = (state == CONV) && (cnt == CONV_END);

  always_comb begin
    res_nx = '0;
    neg_nx = 1'b0;
    dz_nx  = 1'b0;
    unique case (1'b1)
      !op_l[1]: begin
        res_nx = RW'(sum_abs);
        neg_nx = sum[WIDTH];
      end
      op_l == 2'b10: begin
        res_nx = acc_nx;
        neg_nx = a_neg ^ b_neg;
      end
      default: begin
        dz_nx  = (b_mag == '0);
        res_nx = dz_nx ? '0 : RW'(quo_nx);
        neg_nx = a_neg ^ b_neg;
      end
    endcase
    if (res_nx == '0) neg_nx = 1'b0;
  end

  always_comb begin
    adj = bcd_sr;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_sr[4*i +: 4] > 4'd4)
        adj[4*i +: 4] = bcd_sr[4*i +: 4] + 4'd3;
    end
    bcd_nx = (adj << 1) | BW'(bin_sr[RW-1]);
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b1;
    done     = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nx = LOAD;
      end
      LOAD: state_nx = EXEC;
      EXEC: if (exec_last) state_nx = CONV;
      CONV: if (conv_last) state_nx = DONE;
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: begin
        busy     = 1'b0;
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge ar) begin
    if (!ar) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or negedge ar) begin
    if (!ar) begin
      a_l        <= '0;
      b_l        <= '0;
      op_l       <= '0;
      cnt        <= '0;
      acc        <= '0;
      mcand      <= '0;
      mplier     <= '0;
      rem        <= '0;
      quo        <= '0;
      res_w      <= '0;
      bin_sr     <= '0;
      bcd_sr     <= '0;
      wneg       <= 1'b0;
      wdz        <= 1'b0;
      a_mag      <= '0;
      b_mag      <= '0;
      a_neg      <= 1'b0;
      b_neg      <= 1'b0;
      result_mag <= '0;
      result_neg <= 1'b0;
      div_zero   <= 1'b0;
      bcd        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_l  <= a;
            b_l  <= b;
            op_l <= select;
          end
        end
        LOAD: begin
          a_mag  <= a_abs;
          b_mag  <= b_abs;
          a_neg  <= a_l[WIDTH-1];
          b_neg  <= b_l[WIDTH-1];
          acc    <= '0;
          mcand  <= RW'(a_abs);
          mplier <= b_abs;
          rem    <= '0;
          quo    <= a_abs;
          cnt    <= '0;
        end
        EXEC: begin
          acc    <= acc_nx;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          rem    <= rem_nx;
          quo    <= quo_nx;
          cnt    <= cnt + CW'(1);
          if (exec_last) begin
            res_w  <= res_nx;
            bin_sr <= res_nx;
            bcd_sr <= '0;
            wneg   <= neg_nx;
            wdz    <= dz_nx;
            cnt    <= '0;
          end
        end
        CONV: begin
          bin_sr <= bin_sr << 1;
          bcd_sr <= bcd_nx;
          cnt    <= cnt + CW'(1);
          if (conv_last) begin
            result_mag <= res_w;
            result_neg <= wneg;
            div_zero   <= wdz;
            bcd        <= bcd_nx;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_bcd_seq.sv
// tb_alu_bcd_seq: directed and random operations checked against an
// integer-arithmetic reference for result, sign, BCD and latency.
module tb_alu_bcd_seq;
  localparam int W = 8;
  localparam int D = 5;

  logic           clk = 1'b0;
  logic           ar;
  logic           start;
  logic [1:0]     select;
  logic [W-1:0]   a, b;
  logic           busy, done;
  logic [W-1:0]   a_mag, b_mag;
  logic           a_neg, b_neg;
  logic [2*W-1:0] result_mag;
  logic           result_neg, div_zero;
  logic [4*D-1:0] bcd;
  logic [57:0]    outs;

  int vectors = 0;
  int miscompares = 0;

  alu_bcd_seq #(.WIDTH(W), .DIGITS(D)) dut (
    .clk(clk), .ar(ar), .start(start), .select(select),
    .a(a), .b(b), .busy(busy), .done(done),
    .a_mag(a_mag), .b_mag(b_mag), .a_neg(a_neg), .b_neg(b_neg),
    .result_mag(result_mag), .result_neg(result_neg),
    .div_zero(div_zero), .bcd(bcd)
  );

  always #10 clk = ~clk;

  assign outs = {busy, done, a_mag, b_mag, a_neg, b_neg,
                 result_mag, result_neg, div_zero, bcd};

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic [1:0] s, input logic [W-1:0] oa,
                        input logic [W-1:0] ob, input int acc_exp,
                        input bit noise);
    int av, bv, r, m, t, k;
    bit dz, got;
    logic [4*D-1:0] eb;
    av = int'($signed(oa));
    bv = int'($signed(ob));
    dz = 1'b0;
    case (s)
      2'b00: r = av + bv;
      2'b01: r = av - bv;
      2'b10: r = av * bv;
      default: begin
        if (bv == 0) begin
          dz = 1'b1;
          r  = 0;
        end else begin
          r = av / bv;
        end
      end
    endcase
    m  = (r < 0) ? -r : r;
    eb = '0;
    t  = m;
    for (int i = 0; i < D; i++) begin
      eb[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end

    select = s;
    a      = oa;
    b      = ob;
    start  = 1'b1;
    k   = 0;
    got = 1'b0;
    while (!got && k < 4) begin
      @(posedge clk); #1;
      k++;
      got = busy;
    end
    chk("accept_edge", k, acc_exp);
    start = 1'b0;

    k   = 0;
    got = 1'b0;
    while (!got && k < 40) begin
      if (noise) begin
        start  = 1'($urandom);
        a      = W'($urandom);
        b      = W'($urandom);
        select = 2'($urandom);
      end
      @(posedge clk); #1;
      k++;
      got = done;
    end
    start = 1'b0;
    chk("latency", k, s[1] ? 25 : 18);
    chk("busy_at_done", busy, 1);
    chk("result_mag", result_mag, m);
    chk("result_neg", result_neg, r < 0);
    chk("div_zero", div_zero, dz);
    chk("bcd", bcd, eb);
    chk("a_mag", a_mag, (av < 0) ? -av : av);
    chk("b_mag", b_mag, (bv < 0) ? -bv : bv);
    chk("a_neg", a_neg, av < 0);
    chk("b_neg", b_neg, bv < 0);
  endtask

  initial begin
    int  n_done;
    bit  gap;
    ar     = 1'b0;
    start  = 1'b0;
    select = '0;
    a      = '0;
    b      = '0;
    #25;
    chk("reset_outputs", outs, 0);
    @(negedge clk);
    ar = 1'b1;
    @(posedge clk); #1;

    run_op(2'b00, 8'hF9, 8'h05, 1, 1'b0);
    run_op(2'b10, 8'h80, 8'h80, 2, 1'b0);
    run_op(2'b11, 8'h9C, 8'h07, 2, 1'b0);
    run_op(2'b11, 8'h05, 8'h00, 2, 1'b0);
    run_op(2'b00, 8'h01, 8'h01, 2, 1'b0);
    run_op(2'b10, 8'h00, 8'hFD, 2, 1'b0);
    run_op(2'b01, 8'h7F, 8'h80, 2, 1'b1);
    @(posedge clk); #1;
    chk("done_pulse", {done, busy}, 0);
    chk("hold_result", result_mag, 255);

    select = 2'b10;
    a      = 8'h0C;
    b      = 8'h0B;
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
    end
    ar = 1'b0;
    #1;
    chk("reset_abort", outs, 0);
    repeat (2) begin
      @(posedge clk); #1;
    end
    ar = 1'b1;
    n_done = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (done) n_done++;
    end
    chk("no_done_after_abort", n_done, 0);
    run_op(2'b00, 8'h03, 8'h04, 1, 1'b0);

    for (int n = 0; n < 40; n++) begin
      gap = 1'($urandom);
      if (gap) begin
        @(posedge clk); #1;
      end
      run_op(2'($urandom), W'($urandom), W'($urandom),
             gap ? 1 : 2, 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_bcd_seq.md
Name: alu_bcd_seq

Overview:
- Parametrised, multi-cycle successor to the 4-bit combinational ALU and binary-to-BCD path that drives the seven-segment and VGA display.
- Accepts two signed two's-complement WIDTH-bit operands and performs add, sub, multiply or divide under a start/done handshake.
- Produces sign-magnitude results plus DIGITS packed BCD digits from an iterative double-dabble converter, ready for the seven-segment and VGA decoders.

Parameters:
- WIDTH, 8, operand width in bits (signed two's complement, minimum 4).
- DIGITS, 5, number of BCD output digits. Must satisfy 10^DIGITS > 2^(2*WIDTH-2).

Ports:
- clk  input  1  system clock (50 MHz).
- ar  input  1  asynchronous reset, active-low.
- start  input  1  operation request, sampled only in IDLE.
- select  input  2  operation: 00 add, 01 sub (a-b), 10 mul, 11 div (a/b).
- a  input  WIDTH  signed operand A.
- b  input  WIDTH  signed operand B.
- busy  output  1  high from the start-accept edge until done deasserts.
- done  output  1  one-cycle pulse when results are valid.
- a_mag  output  WIDTH  magnitude of the latched A.
- b_mag  output  WIDTH  magnitude of the latched B.
- a_neg  output  1  sign of the latched A.
- b_neg  output  1  sign of the latched B.
- result_mag  output  2*WIDTH  result magnitude.
- result_neg  output  1  result sign.
- div_zero  output  1  latched divide-by-zero flag.
- bcd  output  4*DIGITS  packed BCD of result_mag; the least-significant digit is in [3:0].

Behaviour:
- Reset (ar=0, asynchronous): state goes to IDLE and every output is 0. Reset mid-operation aborts the operation with no done pulse.
- States and transitions:
  - IDLE: start=1 latches a, b and select, then goes to LOAD.
  - LOAD (1 cycle): computes magnitudes and signs, then goes to EXEC.
  - EXEC: 1 cycle for add/sub; WIDTH cycles for mul (shift-add) or div (restoring). Then goes to CONV.
  - CONV: exactly 2*WIDTH double-dabble iterations, then goes to DONE.
  - DONE (1 cycle): done=1, busy=1, then returns to IDLE.
- Latency: done is high in the cycle after edge N, counted from the start-sampling edge (edge 0).
  - add/sub: N = 2*WIDTH+2 (18 for WIDTH=8).
  - mul/div: N = 3*WIDTH+1 (25 for WIDTH=8).
- Handshake:
  - start is ignored while busy=1.
  - Input changes after the accept edge have no effect.
  - A start held high in the DONE cycle is not accepted. It is accepted on the first IDLE cycle, i.e. the cycle after done.
- Output update and hold:
  - a_mag, b_mag, a_neg and b_neg update at LOAD.
  - result_mag, result_neg, div_zero and bcd update only at the edge entering DONE.
  - All of these hold until the next operation's LOAD or DONE edge respectively.
- Arithmetic:
  - Magnitude of -2^(WIDTH-1) is 2^(WIDTH-1) and fits in WIDTH unsigned bits.
  - add/sub are computed at WIDTH+1 bits with no overflow; magnitude is zero-extended to 2*WIDTH.
  - mul: result_neg = a_neg XOR b_neg.
  - div: truncates toward zero, returns the quotient only, result_neg = a_neg XOR b_neg.
  - When result_mag = 0, result_neg is forced to 0, so negative zero is never reported.
- Divide by zero (select=11, b=0): div_zero=1, result_mag=0, result_neg=0, bcd=0, same latency. div_zero clears at the next DONE of any non-faulting operation.
- bcd always equals the decimal value of result_mag. Digits above the value are 0.

Test Plan:
- Reset abort: start a mul with WIDTH=8, assert ar=0 at cycle 10 → all outputs 0, busy=0, no done. Release reset and start add a=3, b=4 → result_mag=7, bcd=0x00007 at N=18.
- Add: a=-7 (0xF9), b=5, select=00 → result_mag=2, result_neg=1, bcd=0x00002, a_mag=7, a_neg=1, b_mag=5, done exactly at N=18.
- Multiply extreme: a=-128, b=-128, select=10 → result_mag=16384, result_neg=0, bcd=0x16384, done at N=25.
- Divide:
  - a=-100, b=7 → result_mag=14, result_neg=1, bcd=0x00014.
  - a=5, b=0 → div_zero=1, result_mag=0, bcd=0, done at N=25.
  - Then add a=1, b=1 → div_zero=0.
- Sub and handshake: a=127, b=-128, select=01 → result_mag=255, bcd=0x00255. Start pulses and operand changes during busy are ignored. A start asserted the cycle after done is accepted.
- Zero sign: a=0, b=-3, select=10 → result_mag=0, result_neg=0, bcd=0.
